// File: rtl/timeout_nivel_param_if.sv
// rtl/timeout_nivel_param_if.sv - button/control inputs and status outputs of the level-selectable timeout
interface timeout_nivel_param_if #(
  parameter int LEVELS = 4,
  parameter int W      = 13
);
  localparam int NW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  logic              seleciona;
  logic [LEVELS-1:0] botoes;
  logic              zera;
  logic              conta;
  logic [NW-1:0]     nivel;
  logic              nivel_valido;
  logic              timeout;
  logic              expirado;
  logic              aviso;
  logic [W-1:0]      db_Q;
  logic [2:0]        db_estado;

  modport master (
    output seleciona, botoes, zera, conta,
    input  nivel, nivel_valido, timeout, expirado, aviso, db_Q, db_estado
  );

  modport slave (
    input  seleciona, botoes, zera, conta,
    output nivel, nivel_valido, timeout, expirado, aviso, db_Q, db_estado
  );
endinterface

// File: rtl/timeout_nivel_param.sv
// rtl/timeout_nivel_param.sv - timeout counter with player-selected difficulty level
// Optional near-expiry warning (aviso) enabled by defining TIMEOUT_AVISO_EN.
module timeout_nivel_param #(
  parameter int LEVELS       = 4,
  parameter int BASE_TIMEOUT = 5000,
  parameter int W            = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  timeout_nivel_param_if.slave  bus
);
  localparam int NW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    RELEASE = 3'd2,
    ARMED   = 3'd3,
    EXPIRED = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [W-1:0]  count, count_next;
  logic [NW-1:0] nivel, nivel_next;
  logic          valido, valido_next;
  logic          timeout_q, timeout_next;
  logic          expirado_q, expirado_next;

  logic [W-1:0]  limite;
  logic [W-1:0]  terminal;
  logic [NW-1:0] lowest;
  logic          any_button;

  // Limit follows the latched level; the level only changes when leaving SELECT.
  assign limite   = W'(BASE_TIMEOUT >> nivel);
  assign terminal = limite - W'(1);

  always_comb begin
    lowest = '0;
    for (int i = LEVELS - 1; i >= 0; i--) begin
      if (bus.botoes[i]) begin
        lowest = NW'(i);
      end
    end
  end

  assign any_button = |bus.botoes;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      nivel      <= '0;
      valido     <= 1'b0;
      timeout_q  <= 1'b0;
      expirado_q <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      nivel      <= nivel_next;
      valido     <= valido_next;
      timeout_q  <= timeout_next;
      expirado_q <= expirado_next;
    end
  end

  always_comb begin
    state_next   = state;
    count_next   = count;
    nivel_next   = nivel;
    valido_next  = valido;
    timeout_next = 1'b0;

    // A select request overrides everything, including a terminal-count expiry.
    if (bus.seleciona) begin
      state_next  = SELECT;
      count_next  = '0;
      valido_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        SELECT: begin
          if (any_button) begin
            nivel_next = lowest;
            state_next = RELEASE;
          end
        end
        RELEASE: begin
          if (!any_button) begin
            state_next  = ARMED;
            count_next  = '0;
            valido_next = 1'b1;
          end
        end
        ARMED: begin
          if (bus.zera) begin
            count_next = '0;
          end else if (bus.conta && (count == terminal)) begin
            count_next   = '0;
            timeout_next = 1'b1;
            state_next   = EXPIRED;
          end else if (bus.conta) begin
            count_next = count + W'(1);
          end
        end
        EXPIRED: begin
          count_next = '0;
          if (bus.zera) begin
            state_next = ARMED;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end

    expirado_next = (state_next == EXPIRED);
  end

`ifdef TIMEOUT_AVISO_EN
  logic [W-1:0] limiar;
  logic         aviso_q;
  logic         aviso_next;

  // Last quarter of the limit, evaluated on the next count so it lines up with db_Q.
  assign limiar     = limite - (limite >> 2);
  assign aviso_next = (state_next == ARMED) && (count_next >= limiar);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aviso_q <= 1'b0;
    end else begin
      aviso_q <= aviso_next;
    end
  end

  assign bus.aviso = aviso_q;
`else
  assign bus.aviso = 1'b0;
`endif

  assign bus.nivel        = nivel;
  assign bus.nivel_valido = valido;
  assign bus.timeout      = timeout_q;
  assign bus.expirado     = expirado_q;
  assign bus.db_Q         = count;
  assign bus.db_estado    = 3'(state);
endmodule

// File: tb/tb_timeout_nivel_param.sv
// tb/tb_timeout_nivel_param.sv - scoreboard bench for timeout_nivel_param with a behavioural game-rule model
module tb_timeout_nivel_param;
  localparam int LEVELS = 4;
  localparam int BASE   = 5000;
  localparam int W      = 13;

  logic clock;
  logic reset;

  timeout_nivel_param_if #(.LEVELS(LEVELS), .W(W)) bus ();

  timeout_nivel_param #(
    .LEVELS(LEVELS),
    .BASE_TIMEOUT(BASE),
    .W(W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [21:0] sb[$];

  // Reference: phase 0 idle, 1 choosing, 2 waiting release, 3 running, 4 expired.
  int   m_st;
  int   m_lvl;
  int   m_cnt;
  logic m_valid;
  logic m_to;

  function automatic logic [21:0] expected_vec();
    int   lim;
    logic av;
    lim = BASE >> m_lvl;
`ifdef TIMEOUT_AVISO_EN
    av = (m_st == 3) && (m_cnt >= lim - lim / 4);
`else
    av = 1'b0;
`endif
    return {2'(m_lvl), m_valid, m_to, (m_st == 4), av, 13'(m_cnt), 3'(m_st)};
  endfunction

  function automatic logic [21:0] actual_vec();
    return {bus.nivel, bus.nivel_valido, bus.timeout, bus.expirado, bus.aviso, bus.db_Q, bus.db_estado};
  endfunction

  task automatic model_reset();
    m_st = 0; m_lvl = 0; m_cnt = 0; m_valid = 1'b0; m_to = 1'b0;
  endtask

  task automatic model(input logic s, input logic [3:0] b, input logic z, input logic c);
    int lim;
    m_to = 1'b0;
    if (s) begin
      m_st = 1; m_cnt = 0; m_valid = 1'b0;
    end else begin
      case (m_st)
        1: if (b != 4'd0) begin
             for (int i = 3; i >= 0; i--) if (b[i]) m_lvl = i;
             m_st = 2;
           end
        2: if (b == 4'd0) begin
             m_st = 3; m_cnt = 0; m_valid = 1'b1;
           end
        3: begin
             lim = BASE >> m_lvl;
             if (z) m_cnt = 0;
             else if (c) begin
               if (m_cnt + 1 == lim) begin
                 m_cnt = 0; m_to = 1'b1; m_st = 4;
               end else begin
                 m_cnt = m_cnt + 1;
               end
             end
           end
        4: begin
             m_cnt = 0;
             if (z) m_st = 3;
           end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic s, input logic [3:0] b, input logic z, input logic c);
    @(negedge clock);
    bus.seleciona = s;
    bus.botoes    = b;
    bus.zera      = z;
    bus.conta     = c;
    model(s, b, z, c);
    sb.push_back(expected_vec());
  endtask

  task automatic select_level(input logic [3:0] b, input int hold);
    step(1'b1, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < hold; k++) step(1'b0, b, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 6000 && m_cnt != target; k++) step(1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic check_now(input string name, input logic [21:0] want);
    logic [21:0] got;
    got = actual_vec();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Monitor: outputs are valid every cycle, so each edge retires one expectation.
  initial begin
    logic [21:0] want;
    logic [21:0] got;
    forever begin
      @(posedge clock);
      #2;
      if (sb.size() > 0) begin
        want = sb.pop_front();
        got  = actual_vec();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL outputs t=%0t got %h want %h", $time, got, want);
        end
      end
    end
  end

  initial begin
    logic [3:0] b;
    int         len;
    reset = 1'b0;
    bus.seleciona = 1'b0;
    bus.botoes    = 4'd0;
    bus.zera      = 1'b0;
    bus.conta     = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #2;
    check_now("reset_state", 22'd0);
    @(negedge clock);
    reset = 1'b1;

    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b0);

    // Level 1, long press, then expiry with conta held high past the limit
    select_level(4'b0010, 200);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (2503) step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (5) step(1'b0, 4'd0, 1'b0, 1'b1);

    // Level 0, restart with zera after 4000 cycles
    select_level(4'b0001, 3);
    repeat (4000) step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    repeat (5002) step(1'b0, 4'd0, 1'b0, 1'b1);

    // Level 3, zera on the terminal cycle
    select_level(4'b1000, 2);
    run_to((BASE >> 3) - 1);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 4'd0, 1'b0, 1'b1);

    // Multiple buttons resolve to the lowest; seleciona mid-count
    select_level(4'b1100, 4);
    repeat (600) step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 4'd0, 1'b0, 1'b1);

    // seleciona on the terminal cycle
    select_level(4'b0100, 1);
    run_to((BASE >> 2) - 1);
    step(1'b1, 4'd0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 4'd0, 1'b0, 1'b1);

    // Asynchronous reset between edges at count 1000
    select_level(4'b0001, 2);
    run_to(1000);
    @(posedge clock);
    #3;
    reset = 1'b0;
    bus.seleciona = 1'b0;
    bus.botoes    = 4'd0;
    bus.zera      = 1'b0;
    bus.conta     = 1'b0;
    #1;
    check_now("async_reset", 22'd0);
    sb.delete();
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) step(1'b0, 4'b0001, 1'b0, 1'b1);

    // Randomised play
    for (int e = 0; e < 10; e++) begin
      step(1'b1, 4'(($urandom_range(0, 1) != 0) ? 4'b0001 : 4'b0000), 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) step(1'b0, 4'd0, 1'b0, 1'b0);
      b = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 2) != 0) b = b | 4'b1000;
      if ($urandom_range(0, 2) != 0) b = b & 4'b1100 | 4'b0100;
      repeat ($urandom_range(1, 5)) step(1'b0, b, 1'b0, 1'b0);
      len = $urandom_range(800, 2200);
      for (int k = 0; k < len; k++) begin
        step(($urandom_range(0, 1999) == 0),
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 299) == 0),
             ($urandom_range(0, 3) != 0));
      end
    end

    repeat (3) @(posedge clock);
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timeout_nivel_param.md
# timeout_nivel_param

Parametrised timeout unit with player-selectable difficulty for the memory-game datapath. After a select request it latches one of LEVELS difficulty levels from the one-hot button bus, waits for button release, then counts qualified clock cycles against a per-level limit. It flags expiry to the game control FSM and optionally warns before expiry. It sits between the button conditioner and the game control unit, and replaces the fixed single-limit timeout counter.

## Interface
- LEVELS, 4, number of difficulty levels; equals button-bus width; range 2..8
- BASE_TIMEOUT, 5000, limit in clock cycles for level 0; level k limit = BASE_TIMEOUT >> k; every level limit ≥ 4
- W, 13, counter width; must satisfy 2^W > BASE_TIMEOUT
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- seleciona  in  1  request level selection; sampled each cycle
- botoes  in  LEVELS  one-hot player buttons (conditioned, synchronous)
- zera  in  1  restart count (e.g. at each accepted play)
- conta  in  1  count enable
- nivel  out  clog2(LEVELS)  latched level index
- nivel_valido  out  1  high once a level is latched and released
- timeout  out  1  one-cycle expiry pulse
- expirado  out  1  level flag, high while in EXPIRED
- aviso  out  1  near-expiry warning (see Configuration)
- db_Q  out  W  current count
- db_estado  out  3  FSM state encoding

## Operation
- States and encoding: IDLE=0, SELECT=1, RELEASE=2, ARMED=3, EXPIRED=4.
- Any state: if seleciona=1, go to SELECT. Also clear nivel_valido, the count and expirado. This has priority over all other inputs.
- IDLE: hold until seleciona.
- SELECT: wait for botoes≠0.
  - Latch nivel = index of the lowest set bit. Multiple bits set are resolved to the lowest index.
  - Go to RELEASE.
- RELEASE: wait for botoes=0, then go to ARMED with count=0 and nivel_valido=1.
- ARMED: limit L = BASE_TIMEOUT >> nivel.
  - If zera=1: count←0. zera beats conta.
  - Else if conta=1 and count=L−1: count←0, timeout pulses, go to EXPIRED.
  - Else if conta=1: count←count+1.
  - Else: hold.
- EXPIRED:
  - expirado=1 and the count is held at 0.
  - zera=1 returns to ARMED with count 0 and the same level.
  - conta is ignored.
- Arithmetic: unsigned, width W. The count never exceeds L−1, so there is no wrap-around.
- The level does not change except through SELECT. botoes is ignored outside SELECT and RELEASE.

## Timing
- Reset values: state IDLE, nivel=0, nivel_valido=0, timeout=0, expirado=0, aviso=0, db_Q=0, db_estado=0.
- All outputs are registered.
- timeout and expirado:
  - Both rise in the cycle after the edge at which count=L−1 with conta=1.
  - With conta held high from count 0, timeout is high in the cycle after exactly L enabled cycles.
  - timeout lasts exactly one cycle.
- zera at the terminal cycle: no timeout pulse; count becomes 0.
- seleciona at the terminal cycle: no timeout pulse; state becomes SELECT.
- nivel_valido rises one cycle after the first cycle with botoes=0 in RELEASE.
- Latency from the button press to nivel being valid is 1 cycle.
- Reset asserted mid-count: all outputs return to their reset values asynchronously. Operation resumes in IDLE on the first edge after release.

## Configuration
- TIMEOUT_AVISO_EN defined:
  - aviso=1 while in ARMED and count ≥ L − (L>>2), i.e. in the last quarter of the limit.
  - aviso is registered, with the same one-cycle register delay as db_Q.
  - aviso is 0 in all other states.
- TIMEOUT_AVISO_EN undefined: aviso is tied to 0 and the comparator logic is omitted.

## Test plan
- Reset and select level 1:
  - Release reset, pulse seleciona, apply botoes=0010 for 200 cycles, then 0000.
  - Expect nivel=1, nivel_valido=1 and db_estado=3 one cycle after release.
- Level-1 expiry:
  - In ARMED, zera then conta=1 continuously.
  - Expect db_Q to reach 2499, timeout high for one cycle after 2500 enabled cycles, expirado=1 and db_estado=4.
  - With the macro on, aviso=1 from count 1875.
- Zera restart:
  - Level 0 (botoes=0001), conta=1 for 4000 cycles, pulse zera, continue.
  - Expect no timeout until 5000 cycles after zera.
- Tie at terminal count:
  - Assert zera on the cycle count=L−1.
  - Expect no timeout pulse, db_Q=0 and state still ARMED.
- Multiple buttons and reselect:
  - In SELECT, apply botoes=1100; expect nivel=2 (limit 1250).
  - Pulse seleciona mid-count; expect nivel_valido=0 and db_Q=0 next cycle.
- Async reset mid-count:
  - Drop reset at count 1000 between clock edges.
  - Expect all outputs at reset values immediately, and IDLE after release.
